// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters.
// Grants one transaction at a time, tracks completion/timeout and returns a one-cycle response.
module spi_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SPI_TRF_BIT = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [2*NUM_REQ-1:0]           req_mode,
    input  logic [NUM_REQ*SPI_TRF_BIT-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [SPI_TRF_BIT-1:0]         rsp_rdata,
    output logic                           rsp_err,
    output logic [1:0]                     spi_req,
    output logic [SPI_TRF_BIT-1:0]         spi_din,
    input  logic [SPI_TRF_BIT-1:0]         spi_dout,
    input  logic                           spi_done_tx,
    input  logic                           spi_done_rx,
    input  logic                           spi_idle
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 16) ? $clog2(TIMEOUT_CYC + 1) : 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       owner;
    logic [1:0]             mode_q;
    logic [SPI_TRF_BIT-1:0] rdata_q;
    logic                   err_q;
    logic                   tx_seen;
    logic                   rx_seen;
    logic [CNT_W-1:0]       cnt;

    logic [1:0]             mode_arr  [NUM_REQ];
    logic [SPI_TRF_BIT-1:0] wdata_arr [NUM_REQ];
    logic                   grant_any;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       cand_idx;
    int                     cand;
    logic                   accept;
    logic [1:0]             sel_mode;
    logic [SPI_TRF_BIT-1:0] sel_wdata;
    logic                   tx_now;
    logic                   rx_now;
    logic                   done;

    // Unpack the flat per-requester buses
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            mode_arr[i]  = req_mode[2*i +: 2];
            wdata_arr[i] = req_wdata[i*SPI_TRF_BIT +: SPI_TRF_BIT];
        end
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = int'(last_grant) + 1 + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            cand_idx = IDX_W'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign accept    = !rst && (state == IDLE) && spi_idle && grant_any;
    assign sel_mode  = mode_arr[grant_idx];
    assign sel_wdata = wdata_arr[grant_idx];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Completion: sticky done flags merged with this cycle's pulses
    assign tx_now = tx_seen | spi_done_tx;
    assign rx_now = rx_seen | spi_done_rx;

    always_comb begin
        case (mode_q)
            2'd1:    done = tx_now;
            2'd2:    done = rx_now;
            2'd3:    done = tx_now & rx_now;
            default: done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            mode_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tx_seen    <= 1'b0;
            rx_seen    <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            spi_req    <= '0;
            spi_din    <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        mode_q     <= sel_mode;
                        rdata_q    <= '0;
                        tx_seen    <= 1'b0;
                        rx_seen    <= 1'b0;
                        cnt        <= '0;
                        if (sel_mode == 2'd0) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            spi_req <= sel_mode;
                            spi_din <= sel_wdata;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt     <= cnt + CNT_W'(1);
                    tx_seen <= tx_now;
                    rx_seen <= rx_now;
                    if (spi_done_rx && mode_q[1]) begin
                        rdata_q <= spi_dout;
                    end
                    if (done) begin
                        spi_req <= '0;
                        spi_din <= '0;
                        state   <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        // Timeout discards any partially received word
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        spi_req <= '0;
                        spi_din <= '0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid[owner] <= 1'b1;
                    rsp_rdata        <= rdata_q;
                    rsp_err          <= err_q;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: vector table plus scoreboarded responses.
module tb_spi_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_mode;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_rdata;
    logic           rsp_err;
    logic [1:0]     spi_req;
    logic [W-1:0]   spi_din;
    logic [W-1:0]   spi_dout;
    logic           spi_done_tx;
    logic           spi_done_rx;
    logic           spi_idle;

    spi_req_arbiter #(.NUM_REQ(N), .SPI_TRF_BIT(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .spi_req(spi_req), .spi_din(spi_din),
        .spi_dout(spi_dout), .spi_done_tx(spi_done_tx),
        .spi_done_rx(spi_done_rx), .spi_idle(spi_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int onehot;
        int rdata;
        int err;
        int due;
    } exp_t;

    // idx, mode, wdata, rx_dly, tx_dly, dout, exp_rdata, exp_err, exp_k (BUSY cycles to completion)
    typedef struct {
        int idx;
        int mode;
        int wdata;
        int rx_dly;
        int tx_dly;
        int dout;
        int exp_rdata;
        int exp_err;
        int exp_k;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input int mode, input int wdata);
        req_valid[idx]          = 1'b1;
        req_mode[2*idx +: 2]    = 2'(mode);
        req_wdata[W*idx +: W]   = 8'(wdata);
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation, on time
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), e.onehot);
                    check("rsp_rdata", 32'(rsp_rdata), e.rdata);
                    check("rsp_err",   32'(rsp_err),   e.err);
                    check("rsp_cycle", cyc,            e.due);
                end
            end
        end
    end

    task automatic run_txn(input vec_t v);
        exp_t e;
        req_valid = '0;
        set_req(v.idx, v.mode, v.wdata);
        #1;
        check("grant", 32'(req_ready), 1 << v.idx);
        e.onehot = 1 << v.idx;
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        e.due    = cyc + v.exp_k + 2;
        sb.push_back(e);
        tick();
        for (int j = 1; j <= v.exp_k; j++) begin
            spi_done_tx = (j == v.tx_dly);
            spi_done_rx = (j == v.rx_dly);
            spi_dout    = (j == v.rx_dly) ? 8'(v.dout) : 8'hEE;
            #1;
            check("spi_busy", 32'({spi_req, spi_din}), 32'({2'(v.mode), 8'(v.wdata)}));
            check("ready_busy", 32'(req_ready), 32'd0);
            tick();
        end
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        spi_dout    = 8'h00;
        check("ready_resp", 32'(req_ready), 32'd0);
        req_valid = '0;
        #1;
        check("spi_resp", 32'({spi_req, spi_din}), 32'd0);
        tick();
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{0, 1, 'hA5, 0,  3,  'h00, 'h00, 0, 3};
        vecs[1] = '{2, 3, 'h3C, 2,  12, 'h5A, 'h5A, 0, 12};
        vecs[2] = '{1, 3, 'hC3, 7,  4,  'h99, 'h99, 0, 7};
        vecs[3] = '{3, 3, 'h11, 5,  5,  'h77, 'h77, 0, 5};
        vecs[4] = '{1, 2, 'h00, 1,  0,  'hE1, 'hE1, 0, 1};
        vecs[5] = '{0, 1, 'hA5, 2,  6,  'hFF, 'h00, 0, 6};
        vecs[6] = '{2, 1, 'h5A, 0,  0,  'h00, 'h00, 1, 16};
        vecs[7] = '{3, 3, 'h81, 3,  0,  'h42, 'h00, 1, 16};
        vecs[8] = '{1, 0, 'hFE, 0,  0,  'h00, 'h00, 1, 0};
        vecs[9] = '{0, 2, 'h3F, 16, 1,  'h3F, 'h3F, 0, 16};

        rst         = 1'b1;
        req_valid   = '1;
        req_mode    = {N{2'd1}};
        req_wdata   = '1;
        spi_dout    = '0;
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        spi_idle    = 1'b1;

        // Outputs quiet during and just after reset
        tick();
        tick();
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_spi_req", 32'(spi_req), 32'd0);
        check("rst_spi_din", 32'(spi_din), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        tick();
        check("post_rst_spi", 32'({spi_req, spi_din}), 32'd0);
        check("post_rst_rsp", 32'(rsp_valid), 32'd0);

        // Fairness: all requesters valid, mode 2, one-cycle completion
        for (int i = 0; i < int'(N); i++) set_req(i, 2, 'h11 * i);
        for (int n = 0; n < 5; n++) begin
            #1;
            check("rr_grant", 32'(req_ready), 1 << (n % N));
            e.onehot = 1 << (n % N);
            e.rdata  = 'h80 + n;
            e.err    = 0;
            e.due    = cyc + 3;
            sb.push_back(e);
            tick();
            spi_done_rx = 1'b1;
            spi_dout    = 8'(8'h80 + n);
            tick();
            spi_done_rx = 1'b0;
            spi_dout    = 8'h00;
            tick();
        end
        #1;
        req_valid = '0;
        tick();

        // spi_idle low blocks grants; done pulses in IDLE are ignored
        spi_idle = 1'b0;
        set_req(1, 1, 'h55);
        for (int n = 0; n < 3; n++) begin
            spi_done_tx = 1'b1;
            spi_done_rx = 1'b1;
            #1;
            check("idle_gate_ready", 32'(req_ready), 32'd0);
            check("idle_gate_spi", 32'(spi_req), 32'd0);
            tick();
        end
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        spi_idle    = 1'b1;
        req_valid   = '0;
        tick();

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Reset during a full-duplex transfer
        req_valid = '0;
        set_req(1, 3, 'h66);
        #1;
        check("mid_grant", 32'(req_ready), 32'h2);
        tick();
        #1;
        check("mid_busy_spi", 32'(spi_req), 32'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_spi_req", 32'(spi_req), 32'd0);
        check("mid_rst_spi_din", 32'(spi_din), 32'd0);
        for (int i = 0; i < int'(N); i++) set_req(i, 0, 0);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h1);
        e.onehot = 1;
        e.rdata  = 0;
        e.err    = 1;
        e.due    = cyc + 2;
        sb.push_back(e);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one SPI master.
REQ-002 The block SHALL have parameter SPI_TRF_BIT, default 8, meaning bits per SPI transfer.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, meaning maximum BUSY cycles before abort.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid  input  NUM_REQ  per-requester transaction request.
REQ-007 The block SHALL have port req_mode  input  2*NUM_REQ  per-requester mode: 1 MOSI-only, 2 MISO-only, 3 full duplex, 0 illegal.
REQ-008 The block SHALL have port req_wdata  input  NUM_REQ*SPI_TRF_BIT  per-requester transmit word.
REQ-009 The block SHALL have port req_ready  output  NUM_REQ  one-hot grant/accept pulse.
REQ-010 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot completion pulse.
REQ-011 The block SHALL have port rsp_rdata  output  SPI_TRF_BIT  received word, valid with rsp_valid.
REQ-012 The block SHALL have port rsp_err  output  1  error flag, valid with rsp_valid.
REQ-013 The block SHALL have port spi_req  output  2  mode to SPI master (0 = no request).
REQ-014 The block SHALL have port spi_din  output  SPI_TRF_BIT  word to SPI master din_master.
REQ-015 The block SHALL have ports spi_dout  input  SPI_TRF_BIT, spi_done_tx  input  1, spi_done_rx  input  1, spi_idle  input  1 (master tx and rx FSMs both idle).

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, RESP.
REQ-017 In IDLE with spi_idle=1 and any req_valid=1, the block SHALL combinationally assert req_ready for exactly one requester, chosen round-robin starting at (last_grant+1) mod NUM_REQ.
REQ-018 On the edge where req_valid&req_ready, the block SHALL capture owner index, mode and wdata, update last_grant, and enter BUSY (mode 1-3) or RESP (mode 0).
REQ-019 req_ready SHALL be 0 in BUSY and RESP, and 0 in IDLE while spi_idle=0.
REQ-020 In BUSY, spi_req SHALL equal the captured mode and spi_din the captured wdata, stable for the whole state; both SHALL be 0 in IDLE and RESP.
REQ-021 Completion SHALL be: mode 1 on spi_done_tx; mode 2 on spi_done_rx; mode 3 when both have been seen, in either order or same cycle, via sticky flags cleared on entry to BUSY.
REQ-022 spi_dout SHALL be latched in the cycle spi_done_rx=1 during BUSY; rsp_rdata SHALL be 0 for mode 1 and mode 0.
REQ-023 A 16-bit-or-wider cycle counter SHALL clear on BUSY entry and increment each BUSY cycle; reaching TIMEOUT_CYC without completion SHALL force RESP with rsp_err=1 and rdata=0.
REQ-024 On completion the block SHALL go to RESP next cycle; spi_req returns to 0 that same cycle.
REQ-025 RESP SHALL last exactly one cycle, asserting rsp_valid[owner]=1, rsp_rdata and rsp_err (1 only for mode 0 or timeout), then return to IDLE.
REQ-026 done pulses arriving in IDLE or RESP SHALL be ignored.
REQ-027 Grant-to-rsp_valid latency SHALL be 2 cycles for mode 0 and (cycles until completion)+2 otherwise.
REQ-028 A requester dropping req_valid before grant SHALL simply not be granted; no state is held for it.

Reset
REQ-029 While rst=1 at a clock edge, the FSM SHALL go to IDLE, last_grant to NUM_REQ-1 (requester 0 first), counters, sticky flags and latches to 0.
REQ-030 Outputs req_ready, rsp_valid, rsp_rdata, rsp_err, spi_req, spi_din SHALL be 0 during and after reset until a grant; reset mid-BUSY SHALL drop spi_req to 0 the next cycle with no rsp_valid.

Verification
REQ-031 Single MOSI: req_valid[0]=1, mode 1, wdata 0xA5 -> req_ready[0] one cycle, spi_req=1, spi_din=0xA5 until done_tx, then rsp_valid[0] with rdata 0x00, err 0.
REQ-032 Full duplex ordering: requester 2 mode 3 wdata 0x3C; done_rx (spi_dout 0x5A) 10 cycles before done_tx -> rsp_valid[2] only after done_tx, rdata 0x5A.
REQ-033 Fairness: all four requesters valid continuously, mode 2 -> grant order 0,1,2,3,0; no requester granted twice before others.
REQ-034 Timeout: TIMEOUT_CYC=16, mode 1, no done_tx -> rsp_valid with err=1 after 16 BUSY cycles; spi_req 0 afterwards.
REQ-035 Illegal/idle gating: mode 0 -> rsp err=1 two cycles after grant, spi_req never nonzero; spi_idle=0 holds req_ready at 0.
REQ-036 Reset mid-BUSY: rst=1 for one cycle during mode 3 -> spi_req 0 next cycle, no rsp_valid, next grant goes to requester 0.
